multi_freq_divider: RTL
=======================

MULTI_FREQ_DIVIDER -- requirements
Module: multi_freq_divider

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 16: width of divisor, high-time and period counter.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Enable  input  NUM_CH  per-channel run enable, level-sensitive.
REQ-006 ConfigDiv  input  1  one-cycle config write strobe.
REQ-007 CfgCh  input  max(1,$clog2(NUM_CH))  target channel of the write.
REQ-008 Din  input  CNT_W  divisor D, in Clk cycles per output period.
REQ-009 DutyHigh  input  CNT_W  high time H, in Clk cycles; 0 selects default duty.
REQ-010 CfgAck  output  1  one-cycle pulse acknowledging an accepted write.
REQ-011 ClkOutput  output  NUM_CH  registered divided waveform per channel.
REQ-012 Tick  output  NUM_CH  one-cycle pulse at the start of each output period.

Function
REQ-013 The block SHALL be fully synchronous to Clk: Clk is never used as data, and no logic is sensitive to Enable edges.
REQ-014 Each channel SHALL hold active (D_a, H_a) and pending (D_p, H_p, pend_valid) registers.
REQ-015 Effective D SHALL be max(Din,1); effective H SHALL be floor(D/2) when DutyHigh=0, else min(DutyHigh, D-1), then max(result,1) when D>=2.
REQ-016 D=1 SHALL give ClkOutput constant 1 and Tick every cycle while running.
REQ-017 A write (ConfigDiv=1 with CfgCh<NUM_CH) SHALL load pending registers, set pend_valid, and pulse CfgAck the next cycle; CfgCh>=NUM_CH SHALL be ignored with no CfgAck.
REQ-018 A second write before application SHALL overwrite the pending values; the last write wins.
REQ-019 Channel FSM states: IDLE (Enable=0) and RUN (Enable=1); IDLE->RUN when Enable=1; RUN->IDLE when Enable=0.
REQ-020 In IDLE, a pending config SHALL be applied to the active registers on the cycle after the write.
REQ-021 In RUN, a pending config SHALL be applied only when cnt wraps from D_a-1 to 0, so no truncated period occurs.
REQ-022 On IDLE->RUN, cnt SHALL be 0; ClkOutput SHALL be 1 and Tick SHALL pulse on the first cycle after Enable is sampled high (latency 1).
REQ-023 In RUN, cnt SHALL count 0..D_a-1 and wrap; ClkOutput SHALL be registered (cnt<H_a); Tick SHALL be registered (cnt==0).
REQ-024 On RUN->IDLE, ClkOutput and Tick SHALL be 0 from the next cycle, and cnt SHALL clear to 0.
REQ-025 A write and an Enable change on the same cycle SHALL evaluate Enable first; the write follows REQ-020/021 for the resulting state.
REQ-026 Channels SHALL be independent; a write to one channel SHALL not perturb the others.

Reset
REQ-027 When Reset=1 on a Clk edge: all ClkOutput=0, Tick=0, CfgAck=0, cnt=0, FSM=IDLE, D_a=2, H_a=1, pend_valid=0.
REQ-028 Reset SHALL override Enable and ConfigDiv on the same cycle, and SHALL abort a running period immediately.

Structure
REQ-029 Package freq_div_pkg SHALL hold the default NUM_CH/CNT_W constants, the channel state enum (IDLE, RUN), and the effective-H helper function.
REQ-030 One sub-module, freq_div_channel, SHALL implement a single channel; the top level SHALL instantiate it NUM_CH times and decode CfgCh/CfgAck.

Verification
REQ-031 Reset, then Enable[0]=1 with default config -> ClkOutput[0] pattern 1,0,1,0; Tick[0] on each high cycle.
REQ-032 Write ch1 D=5, H=0 while idle, then enable -> period 5, high 2 cycles, low 3 cycles; CfgAck pulses once.
REQ-033 Ch2 running D=4, H=1; write D=6, H=3 mid-period -> the current 4-cycle period completes, then 6-cycle periods with 3 cycles high.
REQ-034 Write ch0 D=0, then D=8 with H=20 -> D=0 gives constant high with Tick every cycle; H=20 is clipped to 7.
REQ-035 Drop Enable[3] mid-high, assert Reset mid-period on ch1, write CfgCh=NUM_CH -> outputs 0 next cycle, state returns to reset values, no CfgAck.
REQ-036 All channels enabled with different D, random writes against a reference model -> zero waveform or Tick mismatches over 10000 cycles.

Source files
------------

// File: rtl/freq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_div_pkg
// Description : Shared constants, channel state type and the high-time helper
//               for the multi-channel clock-enable frequency divider.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_div_pkg;

    localparam int c_NUM_CH_DEFAULT = 4;
    localparam int c_CNT_W_DEFAULT  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // High time for an already-clamped divisor d (d >= 1). h = 0 asks for the
    // default half-period; otherwise h is capped so at least one low cycle
    // remains, and never drops to zero for divisors of two or more.
    function automatic logic [31:0] eff_high(input logic [31:0] d, input logic [31:0] h);
        logic [31:0] r;
        if (h == 32'd0) begin
            r = d >> 1;
        end else if (h < (d - 32'd1)) begin
            r = h;
        end else begin
            r = d - 32'd1;
        end
        if ((d >= 32'd2) && (r == 32'd0)) begin
            r = 32'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_div_channel.sv
`default_nettype none
// ============================================================================
// Module      : freq_div_channel
// Description : One divider channel: active/pending configuration, period
//               counter and registered waveform/tick outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Wr,
    input  logic [CNT_W-1:0] Din,
    input  logic [CNT_W-1:0] DutyHigh,
    output logic             ClkOutput,
    output logic             Tick
);

    chan_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_d_act, w_d_act_nxt;
    logic [CNT_W-1:0] r_h_act, w_h_act_nxt;
    logic [CNT_W-1:0] r_d_pend, w_d_pend_nxt;
    logic [CNT_W-1:0] r_h_pend, w_h_pend_nxt;
    logic             r_pend_valid, w_pend_valid_nxt;
    logic             r_clk_out, w_clk_out_nxt;
    logic             r_tick, w_tick_nxt;
    logic [CNT_W-1:0] w_d_eff, w_h_eff;
    logic             w_wrap, w_apply;

    // Clamp the incoming write to a legal divisor/high-time pair.
    always_comb begin
        w_d_eff = (Din == '0) ? CNT_W'(1) : Din;
        w_h_eff = CNT_W'(eff_high(32'(w_d_eff), 32'(DutyHigh)));
    end

    // Next-state: Enable decides the state first, then pending application,
    // then the write, then the counter and outputs for the resulting state.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_d_act_nxt      = r_d_act;
        w_h_act_nxt      = r_h_act;
        w_d_pend_nxt     = r_d_pend;
        w_h_pend_nxt     = r_h_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_clk_out_nxt    = 1'b0;
        w_tick_nxt       = 1'b0;
        w_wrap           = (r_cnt == (r_d_act - CNT_W'(1)));
        w_apply          = 1'b0;

        case (r_state)
            IDLE:    if (Enable)  w_state_nxt = RUN;
            RUN:     if (!Enable) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // A stopped channel takes new settings at once; a running one only at
        // a period boundary so no period is ever cut short.
        w_apply = r_pend_valid && ((w_state_nxt == IDLE) || ((r_state == RUN) && w_wrap));
        if (w_apply) begin
            w_d_act_nxt      = r_d_pend;
            w_h_act_nxt      = r_h_pend;
            w_pend_valid_nxt = 1'b0;
        end

        if (Wr) begin
            w_d_pend_nxt     = w_d_eff;
            w_h_pend_nxt     = w_h_eff;
            w_pend_valid_nxt = 1'b1;
        end

        if (w_state_nxt == IDLE) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt     = ((r_state == IDLE) || w_wrap) ? '0 : (r_cnt + CNT_W'(1));
            w_clk_out_nxt = (w_d_act_nxt == CNT_W'(1)) || (w_cnt_nxt < w_h_act_nxt);
            w_tick_nxt    = (w_cnt_nxt == '0);
        end
    end

    // State register with synchronous reset to the default divide-by-two.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_d_act      <= CNT_W'(2);
            r_h_act      <= CNT_W'(1);
            r_d_pend     <= CNT_W'(2);
            r_h_pend     <= CNT_W'(1);
            r_pend_valid <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_d_act      <= w_d_act_nxt;
            r_h_act      <= w_h_act_nxt;
            r_d_pend     <= w_d_pend_nxt;
            r_h_pend     <= w_h_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_clk_out    <= w_clk_out_nxt;
            r_tick       <= w_tick_nxt;
        end
    end

    assign ClkOutput = r_clk_out;
    assign Tick      = r_tick;

endmodule
`default_nettype wire

// File: rtl/multi_freq_divider.sv
`default_nettype none
// ============================================================================
// Module      : multi_freq_divider
// Description : NUM_CH independent programmable dividers sharing one config
//               write port; decodes the target channel and acknowledges writes.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_freq_divider
    import freq_div_pkg::*;
#(
    parameter  int NUM_CH = c_NUM_CH_DEFAULT,
    parameter  int CNT_W  = c_CNT_W_DEFAULT,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] Enable,
    input  logic              ConfigDiv,
    input  logic [CH_W-1:0]   CfgCh,
    input  logic [CNT_W-1:0]  Din,
    input  logic [CNT_W-1:0]  DutyHigh,
    output logic              CfgAck,
    output logic [NUM_CH-1:0] ClkOutput,
    output logic [NUM_CH-1:0] Tick
);

    logic              w_wr_valid;
    logic [NUM_CH-1:0] w_wr_ch;
    logic              r_cfg_ack;

    // Writes to a channel index beyond the populated range are dropped.
    assign w_wr_valid = ConfigDiv && (32'(CfgCh) < 32'(NUM_CH));

    // Acknowledge an accepted write one cycle later.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cfg_ack <= 1'b0;
        end else begin
            r_cfg_ack <= w_wr_valid;
        end
    end

    assign CfgAck = r_cfg_ack;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_wr_ch[g] = w_wr_valid && (CfgCh == CH_W'(g));

            freq_div_channel #(
                .CNT_W (CNT_W)
            ) u_chan (
                .Clk       (Clk),
                .Reset     (Reset),
                .Enable    (Enable[g]),
                .Wr        (w_wr_ch[g]),
                .Din       (Din),
                .DutyHigh  (DutyHigh),
                .ClkOutput (ClkOutput[g]),
                .Tick      (Tick[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire
